// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - PC generator and instruction-fetch stage with exception/branch redirect
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   exc_bus      : {exc_valid, exc_pc} redirect pulse from write-back
//   jbr_bus      : {jbr_taken, jbr_target} pulse from decode
//   ID_allow_in  : decode can accept an instruction this cycle
//   inst_addr    : instruction ROM address (pc_r)
//   inst_rdata   : instruction ROM data for the address presented
//   IF_valid     : IF_ID_bus holds a valid instruction
//   IF_over      : handoff to decode occurs this cycle
//   IF_ID_bus    : {fetch_error, pc, inst}
//   IF_pc        : current PC for display
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] INST_NOP = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [32:0] exc_bus,
  input  logic [32:0] jbr_bus,
  input  logic        ID_allow_in,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  output logic        IF_valid,
  output logic        IF_over,
  output logic [64:0] IF_ID_bus,
  output logic [31:0] IF_pc
);

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_r;
  logic [31:0] next_pc;
  logic        jbr_pend_r;
  logic [31:0] jbr_target_r;
  logic [31:0] inst_r;
  logic        ferr_r;

  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        jbr_taken;
  logic [31:0] jbr_target;
  logic        misaligned;

  assign exc_valid  = exc_bus[32];
  assign exc_pc     = exc_bus[31:0];
  assign jbr_taken  = jbr_bus[32];
  assign jbr_target = jbr_bus[31:0];

  assign inst_addr  = pc_r;
  assign IF_pc      = pc_r;
  assign IF_ID_bus  = {ferr_r, pc_r, inst_r};
  assign misaligned = (pc_r[1:0] != 2'b00);

  // A pending taken branch is only consumed at a handoff, so the instruction
  // handed off in the same cycle as the pulse still advances sequentially.
  assign next_pc = jbr_pend_r ? jbr_target_r : pc_r + 32'd4;

  always_comb begin
    state_next = state;
    IF_valid   = 1'b0;
    IF_over    = 1'b0;
    case (state)
      S_WAIT: begin
        state_next = S_READY;
      end
      S_READY: begin
        IF_valid = 1'b1;
        // An exception redirect kills the instruction sitting in READY.
        IF_over  = ID_allow_in & ~exc_valid;
        if (IF_over) begin
          state_next = S_WAIT;
        end
      end
      default: begin
        state_next = S_WAIT;
      end
    endcase
    if (exc_valid) begin
      state_next = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_WAIT;
      pc_r         <= RESET_PC;
      jbr_pend_r   <= 1'b0;
      jbr_target_r <= 32'd0;
      inst_r       <= 32'd0;
      ferr_r       <= 1'b0;
    end else begin
      state <= state_next;
      if (exc_valid) begin
        // ROM data for the old PC is dropped; a concurrent branch is ignored.
        pc_r       <= exc_pc;
        jbr_pend_r <= 1'b0;
      end else begin
        if (state == S_WAIT) begin
          inst_r <= misaligned ? INST_NOP : inst_rdata;
          ferr_r <= misaligned;
        end
        if (IF_over) begin
          pc_r <= next_pc;
        end
        // A new pulse wins over the consumption of an older pending target.
        if (jbr_taken) begin
          jbr_pend_r   <= 1'b1;
          jbr_target_r <= jbr_target;
        end else if (IF_over) begin
          jbr_pend_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard testbench for fetch_pc
module tb_fetch_pc;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic [32:0] exc_bus;
  logic [32:0] jbr_bus;
  logic        ID_allow_in;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        IF_valid;
  logic        IF_over;
  logic [64:0] IF_ID_bus;
  logic [31:0] IF_pc;

  int errors = 0;
  int checks = 0;
  logic [64:0] sb[$];

  fetch_pc dut (
    .clk        (clk),
    .reset      (reset),
    .exc_bus    (exc_bus),
    .jbr_bus    (jbr_bus),
    .ID_allow_in(ID_allow_in),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .IF_valid   (IF_valid),
    .IF_over    (IF_over),
    .IF_ID_bus  (IF_ID_bus),
    .IF_pc      (IF_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [64:0] exp_bus(input logic [31:0] p);
    logic e;
    e = (p[1:0] != 2'b00);
    return {e, p, e ? 32'h0000_0000 : rom_word(p)};
  endfunction

  // ROM samples the address mid-cycle so its word is ready at the WAIT->READY edge.
  always @(negedge clk) inst_rdata <= rom_word(inst_addr);

  // Scoreboard: every handoff must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && IF_over) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL handoff_unexpected: got bus=%h, expected no handoff", IF_ID_bus);
      end else begin
        logic [64:0] e;
        e = sb.pop_front();
        if (IF_ID_bus !== e) begin
          errors++;
          $display("FAIL handoff_bus: got %h, expected %h", IF_ID_bus, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (IF_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ID_allow_in = 1'b1;
    exc_bus = '0;
    jbr_bus = '0;
    tick();
    tick();
    checks++;
    if (IF_valid !== 1'b0 || IF_over !== 1'b0 || inst_addr !== RESET_PC || IF_pc !== RESET_PC) begin
      errors++;
      $display("FAIL reset_state: got valid=%b over=%b addr=%h pc=%h, expected 0 0 %h %h",
               IF_valid, IF_over, inst_addr, IF_pc, RESET_PC, RESET_PC);
    end
    sb.push_back(exp_bus(32'hBFC00000));
    sb.push_back(exp_bus(32'hBFC00004));
    sb.push_back(exp_bus(32'hBFC00008));
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (IF_valid !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL reset_valid_pattern[%0d]: got %b, expected %b", k, IF_valid, (k % 2) == 0);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_stall();
    logic [64:0] snap_bus;
    logic [31:0] snap_addr;
    ID_allow_in = 1'b0;
    wait_ready(4);
    checks++;
    if (IF_pc !== 32'hBFC0000C) begin
      errors++;
      $display("FAIL stall_pc: got %h, expected %h", IF_pc, 32'hBFC0000C);
    end
    snap_bus  = IF_ID_bus;
    snap_addr = inst_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (IF_ID_bus !== snap_bus || inst_addr !== snap_addr || IF_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got bus=%h addr=%h valid=%b, expected %h %h 1",
                 i, IF_ID_bus, inst_addr, IF_valid, snap_bus, snap_addr);
      end
    end
    sb.push_back(exp_bus(32'hBFC0000C));
    ID_allow_in = 1'b1;
    tick();
    checks++;
    if (IF_pc !== 32'hBFC00010 || IF_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_release: got pc=%h valid=%b pending=%0d, expected %h 0 0",
               IF_pc, IF_valid, sb.size(), 32'hBFC00010);
    end
  endtask

  task automatic test_branch_delay_slot();
    sb.push_back(exp_bus(32'hBFC00010));
    sb.push_back(exp_bus(32'hBFC00014));
    sb.push_back(exp_bus(32'hBFC00100));
    tick();
    // READY at BFC00010 handing off; the branch pulse arrives this cycle.
    jbr_bus = {1'b1, 32'hBFC00100};
    tick();
    jbr_bus = '0;
    wait_drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL branch_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_exception();
    ID_allow_in = 1'b0;
    // Exception and branch together; lands during WAIT of the previous fetch.
    exc_bus = {1'b1, 32'hBFC00020};
    jbr_bus = {1'b1, 32'hBFC00300};
    tick();
    exc_bus = '0;
    jbr_bus = '0;
    wait_ready(4);
    checks++;
    if (IF_ID_bus !== exp_bus(32'hBFC00020)) begin
      errors++;
      $display("FAIL exc_wait_bus: got %h, expected %h", IF_ID_bus, exp_bus(32'hBFC00020));
    end
    sb.push_back(exp_bus(32'hBFC00020));
    ID_allow_in = 1'b1;
    tick();
    ID_allow_in = 1'b0;
    wait_ready(4);
    checks++;
    if (IF_pc !== 32'hBFC00024) begin
      errors++;
      $display("FAIL exc_jbr_ignored: got pc=%h, expected %h", IF_pc, 32'hBFC00024);
    end
    jbr_bus = {1'b1, 32'hBFC00200};
    tick();
    jbr_bus = '0;
    ID_allow_in = 1'b1;
    exc_bus = {1'b1, 32'hBFC00380};
    #1;
    checks++;
    if (IF_over !== 1'b0 || IF_valid !== 1'b1) begin
      errors++;
      $display("FAIL exc_kill_over: got over=%b valid=%b, expected 0 1", IF_over, IF_valid);
    end
    sb.push_back(exp_bus(32'hBFC00380));
    sb.push_back(exp_bus(32'hBFC00384));
    tick();
    exc_bus = '0;
    checks++;
    if (IF_valid !== 1'b0 || IF_pc !== 32'hBFC00380) begin
      errors++;
      $display("FAIL exc_redirect: got valid=%b pc=%h, expected 0 %h", IF_valid, IF_pc, 32'hBFC00380);
    end
    tick();
    checks++;
    if (IF_valid !== 1'b1) begin
      errors++;
      $display("FAIL exc_latency: got valid=%b, expected 1", IF_valid);
    end
    wait_drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL exc_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_misaligned_and_wrap();
    ID_allow_in = 1'b0;
    exc_bus = {1'b1, 32'hBFC00500};
    tick();
    exc_bus = '0;
    wait_ready(4);
    sb.push_back(exp_bus(32'hBFC00500));
    sb.push_back(exp_bus(32'hBFC00504));
    sb.push_back(exp_bus(32'hBFC00102));
    sb.push_back(exp_bus(32'hBFC00106));
    ID_allow_in = 1'b1;
    jbr_bus = {1'b1, 32'hBFC00102};
    tick();
    jbr_bus = '0;
    wait_drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL misaligned_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    ID_allow_in = 1'b0;
    exc_bus = {1'b1, 32'hFFFFFFFC};
    tick();
    exc_bus = '0;
    wait_ready(4);
    sb.push_back(exp_bus(32'hFFFFFFFC));
    sb.push_back(exp_bus(32'h00000000));
    sb.push_back(exp_bus(32'h00000004));
    ID_allow_in = 1'b1;
    wait_drain(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_in_ready();
    ID_allow_in = 1'b0;
    wait_ready(4);
    reset = 1'b1;
    exc_bus = {1'b1, 32'hBFC00700};
    tick();
    exc_bus = '0;
    checks++;
    if (IF_valid !== 1'b0 || IF_pc !== RESET_PC || IF_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got valid=%b pc=%h over=%b, expected 0 %h 0",
               IF_valid, IF_pc, IF_over, RESET_PC);
    end
    reset = 1'b0;
    sb.push_back(exp_bus(RESET_PC));
    ID_allow_in = 1'b1;
    wait_drain(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_restart_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    ID_allow_in = 1'b0;
    exc_bus = '0;
    jbr_bus = '0;
    test_reset();
    test_stall();
    test_branch_delay_slot();
    test_exception();
    test_misaligned_and_wrap();
    test_reset_in_ready();
    ID_allow_in = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
